// File: rtl/fns_pkg.sv
// Shared constants and elaboration-time helpers for the FNS crosstalk-avoidance encoders.
package fns_pkg;

  localparam int CW_MIN = 4;
  localparam int CW_MAX = 48;
  // Digit index width: covers every k up to CW_MAX-1 and sizes the weight tables.
  localparam int K_W    = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fns_state_e;

  function automatic logic bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4);
  endfunction

  // F(1)=F(2)=1; F(n)=0 for n<1.
  function automatic logic [63:0] fns_fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (n < 1) ? 64'd0 : b;
  endfunction

  // ceil(log2(F(cw+2))): smallest width holding every legal input.
  function automatic int fns_data_width(input int cw);
    logic [63:0] lim;
    int w;
    lim = fns_fib(cw + 2);
    w   = 64;
    for (int i = 63; i >= 0; i--)
      if ((64'd1 << i) >= lim) w = i;
    return w;
  endfunction

endpackage

// File: rtl/fns_cac_encoder_iter_if.sv
// Valid/ready request and response bundle between data source, encoder and bus driver.
interface fns_cac_encoder_iter_if #(
  parameter int CW_WIDTH   = 16,
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] datain;
  logic                  in_valid;
  logic                  in_ready;
  logic [CW_WIDTH-1:0]   codeout;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output datain, in_valid, out_ready,
                  input  in_ready, codeout, out_err, out_valid);
  modport slave  (input  datain, in_valid, out_ready,
                  output in_ready, codeout, out_err, out_valid);
endinterface

// File: rtl/fns_digit_stage.sv
// One combinational FNS digit decision: picks codeword bit k and strips its weight from the residue.
module fns_digit_stage
  import fns_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic [DATA_WIDTH-1:0] res_i,
  input  logic                  prev_i,
  input  logic [K_W-1:0]        k_i,
  output logic                  bit_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  // wt[j] = F(j+1), the weight of codeword bit j.
  logic [DATA_WIDTH-1:0] wt [64];
  for (genvar j = 0; j < 64; j++) begin : g_wt
    assign wt[j] = DATA_WIDTH'(fns_fib(j + 1));
  end

  logic [K_W-1:0]        k_nx;
  logic [DATA_WIDTH-1:0] w_lo, w_hi;
  assign k_nx = k_i + K_W'(1);
  assign w_lo = wt[k_i];
  assign w_hi = wt[k_nx];

  always_comb begin
    bit_o = 1'b0;
    if (k_i == '0)         bit_o = res_i[0];
    else if (res_i >= w_hi) bit_o = 1'b1;
    else if (res_i < w_lo)  bit_o = 1'b0;
    else                    bit_o = prev_i;  // ambiguous band: repeat the higher bit
    res_o = bit_o ? (res_i - w_lo) : res_i;
  end

endmodule

// File: rtl/fns_cac_encoder_iter.sv
// Iterative FNS encoder: resolves BPC codeword bits per clock, MSB first, behind valid/ready.
module fns_cac_encoder_iter
  import fns_pkg::*;
#(
  parameter int CW_WIDTH   = 16,
  parameter int BPC        = 1,
  parameter int DATA_WIDTH = fns_data_width(CW_WIDTH)
) (
  input logic                   clock,
  input logic                   reset_n,
  fns_cac_encoder_iter_if.slave bus
);

  localparam int NCYC  = (CW_WIDTH + BPC - 1) / BPC;
  localparam int CNT_W = $clog2(NCYC + 1);
  // One extra bit: F(CW_WIDTH+2) can equal 2**DATA_WIDTH.
  localparam logic [DATA_WIDTH:0] LIMIT = (DATA_WIDTH + 1)'(fns_fib(CW_WIDTH + 2));

  if (CW_WIDTH < CW_MIN || CW_WIDTH > CW_MAX || !bpc_legal(BPC)) begin : g_param_err
    $error("fns_cac_encoder_iter: illegal CW_WIDTH/BPC");
  end

  fns_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  prev_q;
  logic [CW_WIDTH-1:0]   code_q, code_d;
  logic                  err_q, ovld_q;
  logic                  in_ready, take, oor;

  assign in_ready      = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign take          = bus.in_valid && in_ready;
  assign oor           = ({1'b0, bus.datain} >= LIMIT);
  assign bus.in_ready  = in_ready;
  assign bus.codeout   = code_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = ovld_q;

  // Chained digit stages; stages whose k falls below 0 pass residue and prev through.
  logic [BPC:0][DATA_WIDTH-1:0] res_c;
  logic [BPC:0]                 prev_c;
  logic [BPC-1:0][DATA_WIDTH-1:0] stg_res;
  logic [BPC-1:0]               bit_c, live_c;
  logic [BPC-1:0][K_W-1:0]      k_c;

  assign res_c[0]  = res_q;
  assign prev_c[0] = prev_q;

  for (genvar j = 0; j < BPC; j++) begin : g_stg
    int kv;
    always_comb kv = CW_WIDTH - 1 - int'(cnt_q) * BPC - j;
    assign live_c[j] = (kv >= 0);
    assign k_c[j]    = live_c[j] ? K_W'(kv) : '0;

    fns_digit_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stg (
      .res_i  (res_c[j]),
      .prev_i (prev_c[j]),
      .k_i    (k_c[j]),
      .bit_o  (bit_c[j]),
      .res_o  (stg_res[j])
    );

    assign res_c[j+1]  = live_c[j] ? stg_res[j] : res_c[j];
    assign prev_c[j+1] = live_c[j] ? bit_c[j]   : prev_c[j];
  end

  always_comb begin
    code_d = code_q;
    for (int b = 0; b < CW_WIDTH; b++)
      for (int j = 0; j < BPC; j++)
        if (live_c[j] && (k_c[j] == K_W'(b))) code_d[b] = bit_c[j];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      prev_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
      ovld_q  <= 1'b0;
    end else if (take) begin
      // Out-of-range words still walk the full schedule with a zero residue.
      state_q <= ST_RUN;
      cnt_q   <= '0;
      res_q   <= oor ? '0 : bus.datain;
      prev_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= oor;
      ovld_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          res_q  <= res_c[BPC];
          prev_q <= prev_c[BPC];
          code_q <= code_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            state_q <= ST_DONE;
            ovld_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
            ovld_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_cac_encoder_iter.sv
// Scoreboard bench: directed CW16 vectors on BPC=1/4 plus property sweeps on CW8/12/33.
module tb_fns_cac_encoder_iter;

  typedef struct {
    logic [63:0] data;
    logic [63:0] code;
    logic        err;
    int          acc;
  } exp_t;

  logic clk, rst_n;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  exp_t qa[$], qb[$], qc[$], qd[$], qe[$];
  exp_t ea, eb, ec, ed, ee;
  bit   sa, sb, sc, sd, se;

  fns_cac_encoder_iter_if #(.CW_WIDTH(16), .DATA_WIDTH(12)) ifa ();
  fns_cac_encoder_iter_if #(.CW_WIDTH(16), .DATA_WIDTH(12)) ifb ();
  fns_cac_encoder_iter_if #(.CW_WIDTH(8),  .DATA_WIDTH(6))  ifc ();
  fns_cac_encoder_iter_if #(.CW_WIDTH(12), .DATA_WIDTH(9))  ifd ();
  fns_cac_encoder_iter_if #(.CW_WIDTH(33), .DATA_WIDTH(24)) ife ();

  fns_cac_encoder_iter #(.CW_WIDTH(16), .BPC(1)) u_a (.clock(clk), .reset_n(rst_n), .bus(ifa));
  fns_cac_encoder_iter #(.CW_WIDTH(16), .BPC(4)) u_b (.clock(clk), .reset_n(rst_n), .bus(ifb));
  fns_cac_encoder_iter #(.CW_WIDTH(8),  .BPC(2)) u_c (.clock(clk), .reset_n(rst_n), .bus(ifc));
  fns_cac_encoder_iter #(.CW_WIDTH(12), .BPC(4)) u_d (.clock(clk), .reset_n(rst_n), .bus(ifd));
  fns_cac_encoder_iter #(.CW_WIDTH(33), .BPC(1)) u_e (.clock(clk), .reset_n(rst_n), .bus(ife));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic first_valid(input string nm, input int qsz, input int acc, input int ncyc);
    if (qsz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s unexpected out_valid: got 1 expected 0", nm);
    end else cmp({nm, " latency"}, 64'(cyc - acc), 64'(ncyc));
  endtask

  // Sweep words are judged by properties: weighted sum equals input, no 010/101 run.
  task automatic check_word(input string nm, input exp_t e, input logic [63:0] code,
                            input logic err, input int w, input bit sweep);
    logic [63:0] s, a, b, t;
    logic        bad;
    cmp({nm, " err"}, 64'(err), 64'(e.err));
    if (!sweep) cmp({nm, " code"}, code, e.code);
    else begin
      s = 0; a = 1; b = 1; bad = 0;
      for (int k = 0; k < w; k++) begin
        if (code[k]) s += a;
        t = a + b; a = b; b = t;
      end
      for (int k = 0; k + 2 < w; k++)
        if (code[k+:3] == 3'b010 || code[k+:3] == 3'b101) bad = 1;
      cmp({nm, " wsum"}, s, e.data);
      cmp({nm, " pattern"}, 64'(bad), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sa = 0;
    else begin
      if (ifa.out_valid && !sa) begin sa = 1; first_valid("A", qa.size(), qa.size() > 0 ? qa[0].acc : 0, 16); end
      if (ifa.out_valid && ifa.out_ready) begin
        sa = 0;
        if (qa.size() > 0) begin ea = qa.pop_front(); check_word("A", ea, 64'(ifa.codeout), ifa.out_err, 16, 1'b0); end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) sb = 0;
    else begin
      if (ifb.out_valid && !sb) begin sb = 1; first_valid("B", qb.size(), qb.size() > 0 ? qb[0].acc : 0, 4); end
      if (ifb.out_valid && ifb.out_ready) begin
        sb = 0;
        if (qb.size() > 0) begin eb = qb.pop_front(); check_word("B", eb, 64'(ifb.codeout), ifb.out_err, 16, 1'b0); end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) sc = 0;
    else begin
      if (ifc.out_valid && !sc) begin sc = 1; first_valid("C", qc.size(), qc.size() > 0 ? qc[0].acc : 0, 4); end
      if (ifc.out_valid && ifc.out_ready) begin
        sc = 0;
        if (qc.size() > 0) begin ec = qc.pop_front(); check_word("C", ec, 64'(ifc.codeout), ifc.out_err, 8, 1'b1); end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) sd = 0;
    else begin
      if (ifd.out_valid && !sd) begin sd = 1; first_valid("D", qd.size(), qd.size() > 0 ? qd[0].acc : 0, 3); end
      if (ifd.out_valid && ifd.out_ready) begin
        sd = 0;
        if (qd.size() > 0) begin ed = qd.pop_front(); check_word("D", ed, 64'(ifd.codeout), ifd.out_err, 12, 1'b1); end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) se = 0;
    else begin
      if (ife.out_valid && !se) begin se = 1; first_valid("E", qe.size(), qe.size() > 0 ? qe[0].acc : 0, 33); end
      if (ife.out_valid && ife.out_ready) begin
        se = 0;
        if (qe.size() > 0) begin ee = qe.pop_front(); check_word("E", ee, 64'(ife.codeout), ife.out_err, 33, 1'b1); end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int dut, input logic [63:0] d, input logic v);
    case (dut)
      0: begin ifa.datain = d[11:0]; ifa.in_valid = v; end
      1: begin ifb.datain = d[11:0]; ifb.in_valid = v; end
      2: begin ifc.datain = d[5:0];  ifc.in_valid = v; end
      3: begin ifd.datain = d[8:0];  ifd.in_valid = v; end
      4: begin ife.datain = d[23:0]; ife.in_valid = v; end
      default: ;
    endcase
  endtask

  function automatic logic rdy(input int dut);
    case (dut)
      0: return ifa.in_ready;
      1: return ifb.in_ready;
      2: return ifc.in_ready;
      3: return ifd.in_ready;
      4: return ife.in_ready;
      default: return 1'b0;
    endcase
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic send(input int dut, input logic [63:0] d, input bit push,
                      input logic [63:0] code, input logic err, output int waits);
    exp_t e;
    drive(dut, d, 1'b1);
    waits = 0;
    @(negedge clk);
    while (!rdy(dut) && waits < 200) begin waits++; @(negedge clk); end
    if (!rdy(dut)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept dut%0d: in_ready got 0 expected 1", dut);
    end else if (push) begin
      e.data = d; e.code = code; e.err = err; e.acc = cyc + 1;
      case (dut)
        0: qa.push_back(e);
        1: qb.push_back(e);
        2: qc.push_back(e);
        3: qd.push_back(e);
        4: qe.push_back(e);
        default: ;
      endcase
    end
    @(posedge clk); #1;
    drive(dut, d, 1'b0);
  endtask

  initial begin
    int w, n;
    clk = 0;
    rst_n = 0;
    for (int i = 0; i < 5; i++) drive(i, 64'd0, 1'b0);
    ifa.out_ready = 1; ifb.out_ready = 1; ifc.out_ready = 1; ifd.out_ready = 1; ife.out_ready = 1;
    step(3);
    rst_n = 1;
    @(negedge clk);
    cmp("rst A out_valid", 64'(ifa.out_valid), 64'd0);
    cmp("rst A codeout",   64'(ifa.codeout),   64'd0);
    cmp("rst A out_err",   64'(ifa.out_err),   64'd0);
    cmp("rst A in_ready",  64'(ifa.in_ready),  64'd1);
    cmp("rst B in_ready",  64'(ifb.in_ready),  64'd1);
    step(1);

    // Directed CW16/BPC1 vectors, back to back.
    send(0, 987,  1, 64'h6000, 1'b0, w);
    send(0, 0,    1, 64'h0000, 1'b0, w);
    send(0, 1,    1, 64'h0001, 1'b0, w);
    send(0, 2583, 1, 64'hFFFF, 1'b0, w);
    send(0, 2584, 1, 64'h0000, 1'b1, w);
    send(0, 100,  1, 64'h031E, 1'b0, w);

    // Reset mid-run discards the word; nothing is queued for it.
    send(0, 987, 0, 64'h0, 1'b0, w);
    step(3);
    rst_n = 0;
    step(1);
    rst_n = 1;
    @(negedge clk);
    cmp("A post-reset in_ready",  64'(ifa.in_ready),  64'd1);
    cmp("A post-reset out_valid", 64'(ifa.out_valid), 64'd0);
    step(1);
    send(0, 987, 1, 64'h6000, 1'b0, w);

    // CW16/BPC4: stall the output, then consume and accept on the same edge.
    ifb.out_ready = 0;
    send(1, 987, 1, 64'h6000, 1'b0, w);
    n = 0;
    @(negedge clk);
    while (!ifb.out_valid && n < 50) begin n++; @(negedge clk); end
    cmp("B stall out_valid", 64'(ifb.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("B stall codeout",  64'(ifb.codeout),  64'h6000);
      cmp("B stall in_ready", 64'(ifb.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    ifb.out_ready = 1;
    send(1, 2583, 1, 64'hFFFF, 1'b0, w);
    cmp("B same-cycle accept waits", 64'(w), 64'd0);
    send(1, 100,  1, 64'h031E, 1'b0, w);
    send(1, 2584, 1, 64'h0000, 1'b1, w);
    send(1, 1,    1, 64'h0001, 1'b0, w);

    // Property sweeps, including the range ends.
    send(2, 0, 1, 0, 1'b0, w);
    send(2, 54, 1, 0, 1'b0, w);
    for (int i = 0; i < 12; i++) send(2, 64'($urandom_range(0, 54)), 1, 0, 1'b0, w);
    send(3, 0, 1, 0, 1'b0, w);
    send(3, 376, 1, 0, 1'b0, w);
    for (int i = 0; i < 12; i++) send(3, 64'($urandom_range(0, 376)), 1, 0, 1'b0, w);
    send(4, 1, 1, 0, 1'b0, w);
    send(4, 9227464, 1, 0, 1'b0, w);
    for (int i = 0; i < 10; i++) send(4, 64'($urandom_range(0, 9227464)), 1, 0, 1'b0, w);

    n = 0;
    while ((qa.size() + qb.size() + qc.size() + qd.size() + qe.size()) > 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    cmp("drain leftover words", 64'(qa.size() + qb.size() + qc.size() + qd.size() + qe.size()), 64'd0);
    step(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
